// File: rtl/pitch_gen.sv
// Pitch generator: latches the pitch type, sweeps a one-hot ball from MSB to LSB, and resolves the swing as HIT or STRIKE.
// Latency: the ball appears on the edge after the accepted pitch; done rises on the edge that resolves the pitch.
// Backpressure: none; pitch and hit are single-cycle pulses, ignored outside the states that use them.
module pitch_gen #(
    parameter int N_LED      = 8,
    parameter int FAST_TICKS = 3,
    parameter int SLOW_TICKS = 6,
    parameter int HIT_WINDOW = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             pitch,
    input  logic             hit,
    output logic [N_LED-1:0] led,
    output logic             busy,
    output logic             done,
    output logic [1:0]       result
);

    localparam int MAX_TICKS = (FAST_TICKS > SLOW_TICKS) ? FAST_TICKS : SLOW_TICKS;
    localparam int TW        = $clog2(MAX_TICKS);
    localparam int PW        = $clog2(N_LED);

    localparam logic [TW-1:0] FAST_LAST = TW'(FAST_TICKS - 1);
    localparam logic [TW-1:0] SLOW_LAST = TW'(SLOW_TICKS - 1);
    localparam logic [PW-1:0] HALF_P    = PW'(N_LED / 2);
    localparam logic [PW-1:0] LAST_P    = PW'(N_LED - 1);
    localparam logic [PW-1:0] HIT_START = PW'(N_LED - HIT_WINDOW);

    localparam logic [1:0] M_FAST   = 2'd0;
    localparam logic [1:0] M_CHANGE = 2'd1;
    localparam logic [1:0] M_SLIDER = 2'd2;

    localparam logic [1:0] R_NONE   = 2'd0;
    localparam logic [1:0] R_HIT    = 2'd1;
    localparam logic [1:0] R_STRIKE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FLIGHT = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t        r_state, w_state;
    logic [PW-1:0] r_p, w_p;
    logic [TW-1:0] r_timer, w_timer;
    logic [1:0]    r_mode, w_mode;
    logic [1:0]    r_result, w_result;
    logic [TW-1:0] w_last;
    logic [PW-1:0] w_idx;

    // Last timer value of the current step, from the latched pitch type and ball position
    always_comb begin
        w_last = FAST_LAST;
        case (r_mode)
            M_CHANGE: w_last = SLOW_LAST;
            M_SLIDER: w_last = (r_p >= HALF_P) ? SLOW_LAST : FAST_LAST;
            default:  w_last = FAST_LAST;
        endcase
    end

    // Next-state logic: accept pitch, step the ball, resolve swing or final expiry
    always_comb begin
        w_state  = r_state;
        w_p      = r_p;
        w_timer  = r_timer;
        w_mode   = r_mode;
        w_result = r_result;
        case (r_state)
            S_IDLE: begin
                if (pitch) begin
                    w_state  = S_FLIGHT;
                    w_mode   = (mode == 2'd3) ? M_FAST : mode;
                    w_p      = '0;
                    w_timer  = '0;
                    w_result = R_NONE;
                end
            end
            S_FLIGHT: begin
                if (hit) begin
                    // A swing wins over a coinciding final expiry
                    w_result = (r_p >= HIT_START) ? R_HIT : R_STRIKE;
                    w_state  = S_DONE;
                end else if (r_timer == w_last) begin
                    w_timer = '0;
                    if (r_p == LAST_P) begin
                        w_result = R_STRIKE;
                        w_state  = S_DONE;
                    end else begin
                        w_p = r_p + PW'(1);
                    end
                end else begin
                    w_timer = r_timer + TW'(1);
                end
            end
            S_DONE: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_p      <= '0;
            r_timer  <= '0;
            r_mode   <= M_FAST;
            r_result <= R_NONE;
        end else begin
            r_state  <= w_state;
            r_p      <= w_p;
            r_timer  <= w_timer;
            r_mode   <= w_mode;
            r_result <= w_result;
        end
    end

    // Ball display: position p maps to led[N_LED-1-p]; held through the DONE cycle
    always_comb begin
        w_idx = LAST_P - r_p;
        led   = '0;
        if (r_state != S_IDLE) begin
            led[w_idx] = 1'b1;
        end
    end

    assign busy   = (r_state == S_FLIGHT);
    assign done   = (r_state == S_DONE);
    assign result = r_result;

endmodule

// File: tb/tb_pitch_gen.sv
// Bench for pitch_gen: a schedule-based model (elapsed time vs. per-position durations) checked every cycle,
// plus directed runs with hand-computed latencies/results and randomized pitches, swings, noise and resets.
// Inputs change on the falling edge; outputs are compared on the falling edge after each rising edge.
module tb_pitch_gen;

    localparam int N    = 8;
    localparam int FAST = 3;
    localparam int SLOW = 6;
    localparam int HW   = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   mode = 2'd0;
    logic         pitch = 1'b0;
    logic         hit = 1'b0;
    logic [N-1:0] led;
    logic         busy;
    logic         done;
    logic [1:0]   result;

    int n_checks = 0;
    int n_fail   = 0;

    // model state: phase 0 idle, 1 flight, 2 done
    int m_ph   = 0;
    int m_t    = 0;
    int m_md   = 0;
    int m_last = 0;
    int m_res  = 0;

    pitch_gen #(
        .N_LED(N), .FAST_TICKS(FAST), .SLOW_TICKS(SLOW), .HIT_WINDOW(HW)
    ) dut (
        .clk(clk), .rst(rst), .mode(mode), .pitch(pitch), .hit(hit),
        .led(led), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int dur_of(input int md, input int k);
        if (md == 1) return SLOW;
        if (md == 2 && k >= N / 2) return SLOW;
        return FAST;
    endfunction

    function automatic int total_of(input int md);
        int s = 0;
        for (int k = 0; k < N; k++) s += dur_of(md, k);
        return s;
    endfunction

    function automatic int pos_of(input int md, input int t);
        int acc = 0;
        for (int k = 0; k < N; k++) begin
            acc += dur_of(md, k);
            if (t < acc) return k;
        end
        return N - 1;
    endfunction

    task automatic model_step();
        int pos;
        if (rst) begin
            m_ph = 0; m_t = 0; m_res = 0; m_last = 0; m_md = 0;
        end else begin
            case (m_ph)
                0: if (pitch) begin
                    m_ph = 1; m_t = 0; m_res = 0;
                    m_md = (mode == 2'd3) ? 0 : int'(mode);
                end
                1: begin
                    pos = pos_of(m_md, m_t);
                    if (hit) begin
                        m_res = (pos >= N - HW) ? 1 : 2; m_ph = 2; m_last = pos;
                    end else if (m_t == total_of(m_md) - 1) begin
                        m_res = 2; m_ph = 2; m_last = N - 1;
                    end else begin
                        m_t++;
                    end
                end
                default: m_ph = 0;
            endcase
        end
    endtask

    task automatic compare_all();
        logic [N-1:0] one = 1;
        logic [N-1:0] e_led = '0;
        if (m_ph == 1) e_led = one << (N - 1 - pos_of(m_md, m_t));
        if (m_ph == 2) e_led = one << (N - 1 - m_last);
        chk("led", led, e_led);
        chk("busy", busy, (m_ph == 1));
        chk("done", done, (m_ph == 2));
        chk("result", result, m_res);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic run(input logic [1:0] md, input int hit_at, input int noise_at, input int rst_at,
                       input logic hw_in, output int lat, output logic [1:0] res,
                       output logic [N-1:0] ld, output int nd);
        lat = -1; res = 2'd0; ld = '0; nd = 0;
        mode = md; pitch = 1'b1; hit = hw_in;
        cycle();
        pitch = 1'b0; hit = 1'b0;
        chk("acc_led", led, 8'h80);
        chk("acc_busy", busy, 1);
        chk("acc_result", result, 0);
        for (int n = 1; n <= 80; n++) begin
            hit   = (n == hit_at);
            pitch = (n == noise_at);
            if (n == noise_at) mode = md ^ 2'b01;
            rst   = (n == rst_at);
            cycle();
            hit = 1'b0; pitch = 1'b0; rst = 1'b0;
            if (n == rst_at) begin
                chk("rst_led", led, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_result", result, 0);
            end
            if (done) begin
                nd++;
                if (lat < 0) begin lat = n; res = result; ld = led; end
            end
            if (lat >= 0) break;
        end
        if (lat >= 0) begin
            // pitch and swing during the DONE cycle must be ignored
            pitch = 1'b1; hit = 1'b1;
            cycle();
            pitch = 1'b0; hit = 1'b0;
        end
    endtask

    initial begin
        int lat, nd;
        logic [1:0] res;
        logic [N-1:0] ld;

        rst = 1'b1;
        repeat (3) cycle();
        chk("reset_led", led, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_result", result, 0);
        rst = 1'b0;
        cycle();

        run(2'd0, 0, 0, 0, 1'b0, lat, res, ld, nd);
        chk("fast_lat", lat, 24); chk("fast_res", res, 2); chk("fast_led", ld, 8'h01);
        run(2'd1, 0, 0, 0, 1'b0, lat, res, ld, nd);
        chk("change_lat", lat, 48); chk("change_res", res, 2);
        run(2'd2, 0, 0, 0, 1'b0, lat, res, ld, nd);
        chk("slider_lat", lat, 36); chk("slider_res", res, 2);
        run(2'd3, 0, 0, 0, 1'b0, lat, res, ld, nd);
        chk("mode3_lat", lat, 24);

        run(2'd0, 19, 0, 0, 1'b0, lat, res, ld, nd);
        chk("hit02_lat", lat, 19); chk("hit02_res", res, 1); chk("hit02_led", ld, 8'h02);
        run(2'd0, 13, 0, 0, 1'b0, lat, res, ld, nd);
        chk("early_lat", lat, 13); chk("early_res", res, 2); chk("early_led", ld, 8'h08);
        run(2'd0, 24, 0, 0, 1'b0, lat, res, ld, nd);
        chk("final_lat", lat, 24); chk("final_res", res, 1); chk("final_led", ld, 8'h01);

        run(2'd0, 0, 5, 0, 1'b0, lat, res, ld, nd);
        chk("noise_lat", lat, 24); chk("noise_res", res, 2);
        run(2'd0, 0, 0, 0, 1'b1, lat, res, ld, nd);
        chk("idlehit_lat", lat, 24);

        run(2'd0, 0, 0, 10, 1'b0, lat, res, ld, nd);
        chk("rst_ndone", nd, 0);
        run(2'd0, 0, 0, 0, 1'b0, lat, res, ld, nd);
        chk("after_rst_lat", lat, 24);

        run(2'd0, 20, 0, 0, 1'b0, lat, res, ld, nd);
        chk("held_res", res, 1);
        repeat (5) cycle();
        chk("held_idle_result", result, 1);
        chk("held_idle_led", led, 0);
        run(2'd1, 0, 0, 0, 1'b0, lat, res, ld, nd);

        for (int i = 0; i < 30; i++) begin
            logic [1:0] md;
            int ha, na, ra;
            md = 2'($urandom);
            ha = ($urandom % 3 == 0) ? 0 : int'($urandom_range(1, 50));
            na = int'($urandom_range(0, 40));
            ra = ($urandom % 6 == 0) ? int'($urandom_range(1, 30)) : 0;
            if (ra != 0) na = 0;
            run(md, ha, na, ra, 1'($urandom), lat, res, ld, nd);
            repeat ($urandom_range(0, 3)) begin
                hit = 1'($urandom);
                cycle();
                hit = 1'b0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
